ifu_prefetch: RTL and testbench

Parametrised next-generation instruction fetch unit for the pipelined MIPS core. It owns the fetch PC, reads instruction memory combinationally and buffers fetched {pc, instr} pairs in a DEPTH-entry prefetch queue, so decode is decoupled from fetch. Redirects cover branch, jump, jr, exception entry and eret, with delay-slot preservation. Misaligned or out-of-range fetch addresses are flagged as AdEL and halt fetch until the next redirect.

---
 rtl/ifu_prefetch_if.sv | 55 +++++
 rtl/ifu_prefetch.sv | 131 +++++++++++++
 tb/tb_ifu_prefetch.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/ifu_prefetch_if.sv
// Fetch-side bundle of the prefetching IFU: instruction memory port,
// decode-facing queue head handshake and redirect request.
interface ifu_prefetch_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [31:0]   i_inst_addr;
  logic [31:0]   i_inst_rdata;

  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_pc;
  logic [31:0]   out_instr;
  logic          out_adel;
  logic [CW-1:0] out_count;

  logic          redirect_valid;
  logic [2:0]    redirect_op;
  logic [31:0]   redirect_base_pc;
  logic [25:0]   redirect_imm;
  logic [31:0]   redirect_reg;

  modport master (
    output i_inst_addr,
    input  i_inst_rdata,
    output out_valid,
    input  out_ready,
    output out_pc,
    output out_instr,
    output out_adel,
    output out_count,
    input  redirect_valid,
    input  redirect_op,
    input  redirect_base_pc,
    input  redirect_imm,
    input  redirect_reg
  );

  modport slave (
    input  i_inst_addr,
    output i_inst_rdata,
    input  out_valid,
    output out_ready,
    input  out_pc,
    input  out_instr,
    input  out_adel,
    input  out_count,
    output redirect_valid,
    output redirect_op,
    output redirect_base_pc,
    output redirect_imm,
    output redirect_reg
  );
endinterface

// File: rtl/ifu_prefetch.sv
// Instruction fetch unit with a DEPTH-entry prefetch queue, branch/jump/
// exception redirects with delay-slot keep, and AdEL fetch halting.
module ifu_prefetch #(
  parameter int unsigned DEPTH      = 4,
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
  parameter logic [31:0] IM_BASE    = 32'h0000_3000,
  parameter int unsigned IM_WORDS   = 4096
) (
  input  logic           clk,
  input  logic           reset,
  ifu_prefetch_if.master bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [32:0] IM_END =
    {1'b0, IM_BASE} + (33'(IM_WORDS) << 2);

  typedef enum logic {
    FETCH,
    ERR
  } state_t;

  state_t        state, state_n;
  logic [31:0]   fetch_pc, fetch_pc_n;
  logic [AW-1:0] rd_ptr, rd_n;
  logic [AW-1:0] wr_ptr, wr_n;
  logic [CW-1:0] count, cnt_n;

  logic [31:0]   pc_q   [DEPTH];
  logic [31:0]   ins_q  [DEPTH];
  logic          adel_q [DEPTH];

  logic          pop;
  logic          legal;
  logic          redir;
  logic          ds_op;
  logic          do_push;
  logic [31:0]   pc4;
  logic [31:0]   target;

  assign pop   = (count != '0) && bus.out_ready;
  assign legal = (fetch_pc[1:0] == 2'b00)
              && (fetch_pc >= IM_BASE)
              && ({1'b0, fetch_pc} < IM_END);
  assign redir = bus.redirect_valid && (bus.redirect_op <= 3'd4);
  assign ds_op = bus.redirect_op <= 3'd2;
  assign pc4   = bus.redirect_base_pc + 32'd4;

  // Redirect target selection by op.
  always_comb begin
    target = bus.redirect_reg;
    case (bus.redirect_op)
      3'd0: target = pc4 + {{14{bus.redirect_imm[15]}},
                            bus.redirect_imm[15:0], 2'b00};
      3'd1: target = {pc4[31:28], bus.redirect_imm, 2'b00};
      3'd3: target = EXC_VECTOR;
      default: target = bus.redirect_reg;
    endcase
  end

  // Next queue pointers, occupancy, fetch PC and state.
  always_comb begin
    do_push    = 1'b0;
    rd_n       = rd_ptr;
    wr_n       = wr_ptr;
    cnt_n      = count;
    fetch_pc_n = fetch_pc;
    state_n    = state;
    if (redir) begin
      fetch_pc_n = target;
      state_n    = FETCH;
      if (!ds_op || pop) begin
        rd_n  = wr_ptr;
        wr_n  = wr_ptr;
        cnt_n = '0;
      end else if (count != '0) begin
        wr_n  = rd_ptr + AW'(1);
        cnt_n = CW'(1);
      end else if (state == FETCH) begin
        do_push = 1'b1;
        wr_n    = wr_ptr + AW'(1);
        cnt_n   = CW'(1);
      end
    end else begin
      if (pop) rd_n = rd_ptr + AW'(1);
      if (state == FETCH && (count < CW'(DEPTH) || pop)) begin
        do_push = 1'b1;
        wr_n    = wr_ptr + AW'(1);
        if (legal) fetch_pc_n = fetch_pc + 32'd4;
        else       state_n    = ERR;
      end
      cnt_n = count + CW'(do_push) - CW'(pop);
    end
  end

  // Control state; async reset empties the queue at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= FETCH;
      fetch_pc <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      state    <= state_n;
      fetch_pc <= fetch_pc_n;
      rd_ptr   <= rd_n;
      wr_ptr   <= wr_n;
      count    <= cnt_n;
    end
  end

  // Queue storage; contents only matter while counted as valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      pc_q[wr_ptr]   <= fetch_pc;
      ins_q[wr_ptr]  <= legal ? bus.i_inst_rdata : 32'h0;
      adel_q[wr_ptr] <= !legal;
    end
  end

  assign bus.i_inst_addr = fetch_pc;
  assign bus.out_valid   = count != '0;
  assign bus.out_count   = count;
  assign bus.out_pc      = pc_q[rd_ptr];
  assign bus.out_instr   = ins_q[rd_ptr];
  assign bus.out_adel    = adel_q[rd_ptr];

endmodule

// File: tb/tb_ifu_prefetch.sv
// Scoreboard bench for ifu_prefetch: directed fetch/redirect scenarios,
// popped queue heads checked against hand-computed expectations.
module tb_ifu_prefetch;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        adel;
  } ent_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  ent_t exp_q[$];

  ifu_prefetch_if #(.DEPTH(4)) bus ();

  ifu_prefetch dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.i_inst_rdata = bus.i_inst_addr;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic exp_ok(input logic [31:0] pc);
    ent_t e;
    e.pc = pc; e.instr = pc; e.adel = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic exp_adel(input logic [31:0] pc);
    ent_t e;
    e.pc = pc; e.instr = 32'h0; e.adel = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic redirect(input logic [2:0] op, input logic [31:0] base,
                          input logic [25:0] imm, input logic [31:0] r);
    bus.redirect_valid   = 1'b1;
    bus.redirect_op      = op;
    bus.redirect_base_pc = base;
    bus.redirect_imm     = imm;
    bus.redirect_reg     = r;
  endtask

  // Monitor: every accepted head must match the next expected entry.
  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected actual pc=%h required=none",
                 bus.out_pc);
      end else begin
        ent_t e;
        e = exp_q.pop_front();
        if (bus.out_pc !== e.pc || bus.out_instr !== e.instr ||
            bus.out_adel !== e.adel) begin
          errors++;
          $display("FAIL pop actual=%h/%h/%b required=%h/%h/%b",
                   bus.out_pc, bus.out_instr, bus.out_adel,
                   e.pc, e.instr, e.adel);
        end
      end
    end
  end

  initial begin
    bus.out_ready        = 1'b0;
    bus.redirect_valid   = 1'b0;
    bus.redirect_op      = 3'd0;
    bus.redirect_base_pc = 32'h0;
    bus.redirect_imm     = 26'h0;
    bus.redirect_reg     = 32'h0;

    tick(); tick();
    chk("rst_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_count", 32'(bus.out_count), 32'h0);
    chk("rst_addr", bus.i_inst_addr, 32'h3000);

    // Streaming from reset: three pops
    exp_ok(32'h3000); exp_ok(32'h3004); exp_ok(32'h3008);
    reset = 1'b0;
    bus.out_ready = 1'b1;
    chk("first_valid_low", 32'(bus.out_valid), 32'h0);
    tick();
    chk("first_valid_high", 32'(bus.out_valid), 32'h1);
    chk("first_pc", bus.out_pc, 32'h3000);
    tick(); tick(); tick();
    bus.out_ready = 1'b0;

    // Restart and saturate the queue
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("full_count", 32'(bus.out_count), 32'h4);
    chk("full_addr", bus.i_inst_addr, 32'h3010);
    exp_ok(32'h3000); exp_ok(32'h3004);
    exp_ok(32'h3008); exp_ok(32'h300c);
    bus.out_ready = 1'b1;
    tick(); tick(); tick(); tick();
    bus.out_ready = 1'b0;

    // Branch with stalled head: keep head only
    redirect(3'd0, 32'h3000, 26'h000FFFF, 32'h0);
    tick();
    bus.redirect_valid = 1'b0;
    chk("br_count", 32'(bus.out_count), 32'h1);
    chk("br_addr", bus.i_inst_addr, 32'h3000);
    chk("br_head", bus.out_pc, 32'h3010);
    tick(); tick(); tick();
    chk("br_refill", 32'(bus.out_count), 32'h4);

    // Exception flush with same-cycle pop
    exp_ok(32'h3010);
    redirect(3'd3, 32'h0, 26'h0, 32'h0);
    bus.out_ready = 1'b1;
    tick();
    chk("exc_count", 32'(bus.out_count), 32'h0);
    chk("exc_addr", bus.i_inst_addr, 32'h4180);

    // Jump with empty queue: current fetch becomes delay slot
    redirect(3'd1, 32'h3000, 26'h0000C10, 32'h0);
    bus.out_ready = 1'b0;
    tick();
    bus.redirect_valid = 1'b0;
    chk("j_count", 32'(bus.out_count), 32'h1);
    chk("j_addr", bus.i_inst_addr, 32'h3040);
    chk("j_head", bus.out_pc, 32'h4180);

    // jr while popping the delay slot, misaligned target
    exp_ok(32'h4180);
    exp_adel(32'h3002);
    redirect(3'd2, 32'h0, 26'h0, 32'h3002);
    bus.out_ready = 1'b1;
    tick();
    bus.redirect_valid = 1'b0;
    chk("jr_count", 32'(bus.out_count), 32'h0);
    chk("jr_addr", bus.i_inst_addr, 32'h3002);
    tick(); tick(); tick(); tick();
    chk("err_count", 32'(bus.out_count), 32'h0);
    chk("err_addr", bus.i_inst_addr, 32'h3002);

    // Exception leaves ERR, then async reset mid-burst
    redirect(3'd3, 32'h0, 26'h0, 32'h0);
    bus.out_ready = 1'b0;
    tick();
    bus.redirect_valid = 1'b0;
    chk("exc2_addr", bus.i_inst_addr, 32'h4180);
    tick(); tick(); tick();
    chk("burst_count", 32'(bus.out_count), 32'h3);
    chk("burst_addr", bus.i_inst_addr, 32'h418c);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_valid", 32'(bus.out_valid), 32'h0);
    chk("arst_count", 32'(bus.out_count), 32'h0);
    chk("arst_addr", bus.i_inst_addr, 32'h3000);
    tick();
    exp_ok(32'h3000);
    reset = 1'b0;
    bus.out_ready = 1'b1;
    tick(); tick();
    bus.out_ready = 1'b0;
    tick(); tick();

    chk("sb_drained", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
